// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream MSB-first into 32-bit words and writes
// them to consecutive instruction-memory word addresses, one transfer per start.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   start, num_words     transfer request and requested word count
//   in_valid, in_data    byte stream in; in_ready shows a byte can be taken
//   mem_we, mem_addr,    memory write request, held until mem_ack
//   mem_wdata, mem_ack
//   busy, done           transfer in progress / one-cycle completion pulse
//   words_written        words committed in the current or last transfer
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CAP_I = DEPTH - BASE_ADDR;
  localparam logic [ADDR_WIDTH:0] CAP =
    CAP_I[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] BASE =
    BASE_ADDR[ADDR_WIDTH-1:0];

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    FIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [1:0]            byte_idx;
  logic [23:0]           word;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   target;
  logic                  zero_done;

  logic                  start_ok;
  logic                  start_zero;
  logic                  accept;
  logic                  last_byte;
  logic                  ack_ok;
  logic [ADDR_WIDTH:0]   ww_inc;

  assign start_ok   = (state == IDLE) && start
                      && (num_words != '0);
  assign start_zero = (state == IDLE) && start
                      && (num_words == '0);
  assign accept     = (state == COLLECT) && in_valid;
  assign last_byte  = accept && (byte_idx == 2'd3);
  assign ack_ok     = (state == WRITE) && mem_ack;
  assign ww_inc     = words_written + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_ok) state_nx = COLLECT;
      COLLECT: if (last_byte) state_nx = WRITE;
      WRITE: begin
        if (ack_ok)
          state_nx = (ww_inc == target) ? FIN : COLLECT;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == COLLECT);
    mem_we   = (state == WRITE);
    busy     = (state == COLLECT) || (state == WRITE);
    // A zero-length request completes from IDLE without a FIN visit.
    done     = (state == FIN) || zero_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx      <= '0;
      word          <= '0;
      addr          <= '0;
      target        <= '0;
      zero_done     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      words_written <= '0;
    end else begin
      zero_done <= start_zero;
      if (start_ok) begin
        // Clamp so the last address never wraps past the top.
        target        <= (num_words > CAP) ? CAP : num_words;
        addr          <= BASE;
        byte_idx      <= '0;
        word          <= '0;
        words_written <= '0;
      end
      if (start_zero)
        words_written <= '0;
      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        word     <= {word[15:0], in_data};
        if (last_byte) begin
          mem_addr  <= addr;
          mem_wdata <= {word, in_data};
        end
      end
      if (ack_ok) begin
        addr          <= addr + 1'b1;
        words_written <= ww_inc;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and random loads on two instances (base 0 and a
// base near the top of memory) checked against a byte-to-word model.
module tb_imem_loader;

  localparam int AW    = 10;
  localparam int CBASE = 1020;
  localparam int CAP0  = 1024;
  localparam int CAPC  = 1024 - CBASE;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          mem_ack = 1'b0;

  logic          r0, w0, b0, dn0;
  logic [AW-1:0] a0;
  logic [31:0]   d0;
  logic [AW:0]   ww0;
  logic          rc, wc, bc, dnc;
  logic [AW-1:0] ac;
  logic [31:0]   dc;
  logic [AW:0]   wwc;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) u0 (
    .clk(clk), .rst(rst), .start(start),
    .num_words(num_words), .in_valid(in_valid),
    .in_data(in_data), .in_ready(r0), .mem_we(w0),
    .mem_addr(a0), .mem_wdata(d0), .mem_ack(mem_ack),
    .busy(b0), .done(dn0), .words_written(ww0)
  );

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(CBASE)) uc (
    .clk(clk), .rst(rst), .start(start),
    .num_words(num_words), .in_valid(in_valid),
    .in_data(in_data), .in_ready(rc), .mem_we(wc),
    .mem_addr(ac), .mem_wdata(dc), .mem_ack(mem_ack),
    .busy(bc), .done(dnc), .words_written(wwc)
  );

  int vec = 0;
  int errs = 0;
  logic [41:0] q0[$];
  logic [41:0] qc[$];
  logic [7:0]  tx[$];
  int dcnt0 = 0;
  int dcntc = 0;
  int ack_mode = 0;
  int ack_delay = 0;
  int we_run = 0;

  // Memory side: ack policy, committed-write log, done pulse counters.
  always @(negedge clk) begin
    if (w0) we_run++;
    else we_run = 0;
    case (ack_mode)
      0: mem_ack = 1'b1;
      1: mem_ack = w0 && (we_run > ack_delay);
      default: mem_ack = ($urandom_range(0, 2) == 0);
    endcase
    if (!rst && w0 && mem_ack) q0.push_back({a0, d0});
    if (!rst && wc && mem_ack) qc.push_back({ac, dc});
    if (dn0) dcnt0++;
    if (dnc) dcntc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_start(int n);
    start = 1'b1;
    num_words = n[AW:0];
    step();
    start = 1'b0;
  endtask

  task automatic feed(int gap, int poke);
    int i;
    int cyc;
    logic acc;
    i = 0;
    cyc = 0;
    while (i < tx.size() && cyc < 4000) begin
      in_valid = ($urandom_range(0, 99) >= gap);
      in_data = in_valid ? tx[i] : 8'($urandom);
      if (cyc == poke) begin
        start = 1'b1;
        num_words = 11'd1;
      end
      acc = in_valid && r0;
      step();
      start = 1'b0;
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("feed_all_bytes", i, tx.size());
  endtask

  task automatic fill(int n);
    tx.delete();
    for (int i = 0; i < 4 * n; i++)
      tx.push_back(8'($urandom));
  endtask

  task automatic check_writes(int n);
    int e0;
    int ec;
    e0 = (n < CAP0) ? n : CAP0;
    ec = (n < CAPC) ? n : CAPC;
    chk("wr_count0", q0.size(), e0);
    chk("wr_countc", qc.size(), ec);
    for (int i = 0; i < e0 && i < q0.size(); i++) begin
      logic [41:0] ex;
      ex = {10'(i), tx[4*i], tx[4*i+1],
            tx[4*i+2], tx[4*i+3]};
      chk("wr0", q0[i], ex);
    end
    for (int i = 0; i < ec && i < qc.size(); i++) begin
      logic [41:0] ex;
      ex = {10'(CBASE + i), tx[4*i], tx[4*i+1],
            tx[4*i+2], tx[4*i+3]};
      chk("wrc", qc[i], ex);
    end
    chk("words_written0", ww0, e0);
    chk("words_writtenc", wwc, ec);
  endtask

  task automatic finish_load(int n, int bd0, int bdc);
    int c;
    c = 0;
    while (dcnt0 == bd0 && c < 3000) begin
      step();
      c++;
    end
    chk("done_seen", (dcnt0 != bd0), 1);
    step();
    step();
    chk("done_pulses0", dcnt0 - bd0, 1);
    chk("done_pulsesc", dcntc - bdc, 1);
    chk("busy_after0", b0, 0);
    chk("busy_afterc", bc, 0);
    check_writes(n);
  endtask

  task automatic load(int n, int gap, int poke);
    int bd0;
    int bdc;
    q0.delete();
    qc.delete();
    bd0 = dcnt0;
    bdc = dcntc;
    do_start(n);
    chk("busy_on_start", b0, 1);
    feed(gap, poke);
    finish_load(n, bd0, bdc);
  endtask

  initial begin
    int bd0;
    int bdc;
    int i;
    int wecyc;
    logic acc;
    logic pat [7];

    // Reset state
    step();
    step();
    chk("reset_u0", {r0, w0, b0, dn0, ww0, a0, d0}, 0);
    chk("reset_uc", {rc, wc, bc, dnc, wwc, ac, dc}, 0);
    rst = 1'b0;
    step();

    // Basic two-word load, ack tied high
    ack_mode = 0;
    tx = '{8'hDE, 8'hAD, 8'hBE, 8'hEF,
           8'h01, 8'h23, 8'h45, 8'h67};
    load(2, 0, -1);
    chk("basic_word0", q0.size() > 0 ? q0[0][31:0] : 0,
        32'hDEADBEEF);

    // Delayed ack: write held for four cycles
    ack_mode = 1;
    ack_delay = 3;
    tx = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    q0.delete();
    qc.delete();
    bd0 = dcnt0;
    bdc = dcntc;
    do_start(1);
    feed(0, -1);
    wecyc = 0;
    while (w0 && wecyc < 10) begin
      chk("hold_addr", a0, 0);
      chk("hold_data", d0, 32'hCAFEF00D);
      chk("hold_ready", r0, 0);
      wecyc++;
      step();
    end
    chk("hold_cycles", wecyc, 4);
    finish_load(1, bd0, bdc);
    ack_mode = 0;

    // Bursty input valid pattern
    tx = '{8'h12, 8'h34, 8'h56, 8'h78};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    q0.delete();
    qc.delete();
    bd0 = dcnt0;
    bdc = dcntc;
    do_start(1);
    i = 0;
    for (int k = 0; k < 7; k++) begin
      in_valid = pat[k];
      in_data = pat[k] ? tx[i] : 8'hFF;
      acc = in_valid && r0;
      step();
      if (acc) i++;
    end
    in_valid = 1'b0;
    chk("burst_bytes", i, 4);
    finish_load(1, bd0, bdc);

    // Zero-length request
    q0.delete();
    qc.delete();
    bd0 = dcnt0;
    do_start(0);
    chk("zero_done", dn0, 1);
    chk("zero_busy", b0, 0);
    chk("zero_ww", ww0, 0);
    step();
    chk("zero_done_clr", dn0, 0);
    step();
    chk("zero_pulses", dcnt0 - bd0, 1);
    chk("zero_no_write", q0.size() + qc.size(), 0);

    // Reset mid-word, then a clean load
    tx = '{8'hAA, 8'hBB};
    q0.delete();
    qc.delete();
    do_start(1);
    feed(0, -1);
    rst = 1'b1;
    step();
    chk("midrst_u0", {r0, w0, b0, dn0, ww0, a0, d0}, 0);
    chk("midrst_uc", {rc, wc, bc, dnc, wwc, ac, dc}, 0);
    rst = 1'b0;
    step();
    chk("midrst_no_write", q0.size() + qc.size(), 0);
    tx = '{8'h11, 8'h22, 8'h33, 8'h44};
    load(1, 0, -1);
    chk("midrst_word", q0.size() > 0 ? q0[0][31:0] : 0,
        32'h11223344);

    // Clamp near the top of memory, start poked while busy
    fill(10);
    load(10, 0, 3);

    // Random loads with random gaps and random acks
    ack_mode = 2;
    for (int t = 0; t < 8; t++) begin
      int n;
      int gap;
      n = $urandom_range(1, 6);
      gap = $urandom_range(0, 60);
      fill(n);
      load(n, gap, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory path: takes a byte stream from a host or testbench channel and packs every 4 bytes into one 32-bit instruction word, MSB-first.
- Writes each word into the instruction memory at consecutive word addresses.
- The fetch-side reader then consumes the loaded words.
- Programs load one start-to-done transfer at a time, for a given word count.

Parameters:
- ADDR_WIDTH, 10, word-address width; memory depth = 2^ADDR_WIDTH words (1024).
- BASE_ADDR, 0, first word address written by each transfer.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
- num_words  input  ADDR_WIDTH+1  words to load; latched on accepted start.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  block can accept a byte this cycle.
- mem_we  output  1  memory write request.
- mem_addr  output  ADDR_WIDTH  memory word address.
- mem_wdata  output  32  memory write data.
- mem_ack  input  1  memory accepted the write this cycle.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- words_written  output  ADDR_WIDTH+1  words committed in the current or last transfer.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst. At any posedge with rst=1:
  - state goes to IDLE;
  - in_ready, mem_we, mem_addr, mem_wdata, busy, done and words_written become 0;
  - the internal byte index and partial word are cleared.
- State IDLE:
  - in_ready=0, busy=0.
  - start=1 with num_words>0: latch target = min(num_words, 2^ADDR_WIDTH - BASE_ADDR); set addr=BASE_ADDR, byte_idx=0, words_written=0; go to COLLECT.
  - start=1 with num_words=0: words_written=0, done=1 for the next cycle, stay in IDLE.
- State COLLECT:
  - in_ready=1, busy=1.
  - Each cycle with in_valid&&in_ready accepts a byte: word <= {word[23:0], in_data}, byte_idx++. The first byte lands in bits 31:24.
  - in_valid=0 holds everything; gaps are allowed.
  - When the 4th byte is accepted: go to WRITE, mem_we=1, mem_addr=addr, mem_wdata=word (including that byte), byte_idx=0.
- State WRITE:
  - in_ready=0, busy=1.
  - mem_we, mem_addr and mem_wdata stay stable until mem_ack=1 is sampled.
  - On ack: mem_we=0, addr++, words_written++. If words_written+1 == target, go to DONE; otherwise go to COLLECT.
- State DONE:
  - done=1 for exactly one cycle, busy=0, in_ready=0.
  - Returns to IDLE next cycle.
  - words_written holds its value until the next accepted start or rst.
- Latency:
  - The 4th byte is accepted at edge N; mem_we is high in cycle N+1.
  - With mem_ack tied high, the write commits at edge N+1 and the next byte is accepted at edge N+2 at the earliest.
  - After the final ack, done is high in the following cycle.
- Boundaries:
  - start while not in IDLE is ignored.
  - mem_ack outside WRITE is ignored.
  - Bytes offered outside COLLECT are not accepted (in_ready=0).
  - Clamping prevents mem_addr from wrapping past 2^ADDR_WIDTH-1.
  - rst mid-word discards the partial word; no write is issued for it.
  - rst during WRITE drops mem_we at that edge.
- Arithmetic: addr increments modulo 2^ADDR_WIDTH (never wraps because of the clamp). words_written counts with unsigned ADDR_WIDTH+1 bits.

Test Plan:
- Basic load, 2 words: rst, then start with num_words=2, bytes DE AD BE EF 01 23 45 67 with continuous in_valid and mem_ack tied 1 -> writes mem[0]=0xDEADBEEF and mem[1]=0x01234567; done high exactly one cycle; words_written=2; busy low after.
- Delayed ack: num_words=1, mem_ack held 0 for 3 cycles after mem_we rises -> mem_we/mem_addr=0/mem_wdata=0xCAFEF00D stable for 4 cycles; in_ready=0 throughout; exactly one write; then done.
- Bursty input: num_words=1, bytes 12 34 56 78 with in_valid toggling 1,0,0,1,0,1,1 -> mem[0]=0x12345678; no byte dropped or duplicated.
- Zero length: start with num_words=0 -> done pulses on the next cycle; mem_we never asserts; words_written=0.
- Reset mid-operation: rst after 2 bytes (AA BB) -> all outputs 0 on the next cycle. Then start with num_words=1, bytes 11 22 33 44 -> mem[BASE_ADDR]=0x11223344, with no AA/BB residue.
- Clamp: BASE_ADDR=1020, num_words=10, ack tied 1 -> writes addresses 1020..1023 only; words_written=4; done pulses; start while busy is ignored.
